// File: rtl/cpu_pkg.sv
// Shared widths, loader state encoding and opcode field values for the 4-bit CPU slice.
package cpu_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        LD_HOLD,
        LD_RUN,
        LD_LOAD
    } ld_state_t;

    // Opcode occupies instr[7:4], immediate instr[3:0]
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic logic [DATA_W-1:0] make_instr(input logic [3:0] op, input logic [3:0] imm);
        return {op, imm};
    endfunction
endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte-stream loader bus: control pulses plus valid/ready write channel.
interface prog_mem_loader_if;
    import cpu_pkg::*;

    logic              load_start;
    logic              load_end;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output load_start, load_end, wr_valid, wr_data,
        input  wr_ready
    );

    modport slave (
        input  load_start, load_end, wr_valid, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/prog_mem_array.sv
// Program storage: one synchronous write port, one asynchronous read port, no reset.
module prog_mem_array
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with a streaming loader that also sequences the CPU's reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// LD_HOLD | CPU held in reset, hold counter running down to RUN
// LD_RUN  | CPU released, memory read-only, waiting for load_start
// LD_LOAD | CPU held in reset, accepting bytes from word 0 upward
module prog_mem_loader
    import cpu_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   instr,
    prog_mem_loader_if.slave    bus,
    output logic                cpu_n_reset,
    output logic                loading,
    output logic [ADDR_W:0]     load_count,
    output logic [7:0]          checksum
);
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    ld_state_t         state;
    logic [3:0]        hold_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;

    // load_start has priority, so a coincident byte is refused rather than stored
    assign bus.wr_ready = (state == LD_LOAD) && !bus.load_start;
    assign accept       = bus.wr_ready && bus.wr_valid && n_reset;

    prog_mem_array u_array (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (address),
        .rdata (instr)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= LD_HOLD;
            hold_cnt    <= HOLD_INIT;
            cpu_n_reset <= 1'b0;
            wr_ptr      <= '0;
            load_count  <= '0;
            checksum    <= '0;
            loading     <= 1'b0;
        end else if (bus.load_start) begin
            state       <= LD_LOAD;
            cpu_n_reset <= 1'b0;
            wr_ptr      <= '0;
            load_count  <= '0;
            checksum    <= '0;
            loading     <= 1'b1;
        end else begin
            case (state)
                LD_HOLD: begin
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt == 4'd1) begin
                        state       <= LD_RUN;
                        cpu_n_reset <= 1'b1;
                    end
                end
                LD_RUN: begin
                    cpu_n_reset <= 1'b1;
                end
                LD_LOAD: begin
                    if (accept) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        load_count <= load_count + 1'b1;
                        checksum   <= checksum + bus.wr_data;
                    end
                    // The 16th byte always closes the load; the pointer never wraps in use
                    if ((accept && wr_ptr == LAST_PTR) || bus.load_end) begin
                        state    <= LD_HOLD;
                        hold_cnt <= HOLD_INIT;
                        loading  <= 1'b0;
                    end
                end
                default: begin
                    state       <= LD_HOLD;
                    hold_cnt    <= HOLD_INIT;
                    cpu_n_reset <= 1'b0;
                    loading     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench: directed load scenarios plus random traffic against a behavioural model.
module tb_prog_mem_loader;
    import cpu_pkg::*;

    localparam int HOLD = 2;

    logic              clk = 1'b0;
    logic              n_reset;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instr;
    logic              cpu_n_reset;
    logic              loading;
    logic [ADDR_W:0]   load_count;
    logic [7:0]        checksum;

    prog_mem_loader_if bus ();

    prog_mem_loader #(.HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .address     (address),
        .instr       (instr),
        .bus         (bus),
        .cpu_n_reset (cpu_n_reset),
        .loading     (loading),
        .load_count  (load_count),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase 0=held in reset, 1=running, 2=loading
    int          m_phase;
    int          m_hold;
    int          m_ptr;
    int          m_cnt;
    int          m_sum;
    logic [7:0]  m_mem [16];
    bit   [15:0] m_known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive(input logic ls, input logic le, input logic v, input logic [7:0] d);
        bus.load_start = ls;
        bus.load_end   = le;
        bus.wr_valid   = v;
        bus.wr_data    = d;
    endtask

    task automatic model_step();
        if (!n_reset) begin
            m_phase = 0; m_hold = HOLD; m_ptr = 0; m_cnt = 0; m_sum = 0;
        end else if (bus.load_start) begin
            m_phase = 2; m_ptr = 0; m_cnt = 0; m_sum = 0;
        end else if (m_phase == 0) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_phase = 1;
        end else if (m_phase == 2) begin
            if (bus.wr_valid) begin
                m_mem[m_ptr]   = bus.wr_data;
                m_known[m_ptr] = 1'b1;
                m_ptr = m_ptr + 1;
                m_cnt = m_cnt + 1;
                m_sum = (m_sum + int'(bus.wr_data)) % 256;
            end
            if (m_ptr == 16 || bus.load_end) begin
                m_phase = 0; m_hold = HOLD;
            end
        end
    endtask

    // Inputs are set at the falling edge; check combinational outputs, clock, check registered outputs
    task automatic cycle();
        #1;
        chk("wr_ready", 32'(bus.wr_ready), 32'(m_phase == 2 && !bus.load_start));
        if (m_known[address]) chk("instr_pre", 32'(instr), 32'(m_mem[address]));
        model_step();
        @(posedge clk);
        #1;
        chk("cpu_n_reset", 32'(cpu_n_reset), 32'(m_phase == 1));
        chk("loading", 32'(loading), 32'(m_phase == 2));
        chk("load_count", 32'(load_count), 32'(m_cnt));
        chk("checksum", 32'(checksum), 32'(m_sum));
        if (m_known[address]) chk("instr_post", 32'(instr), 32'(m_mem[address]));
        @(negedge clk);
    endtask

    task automatic read_word(input int a, input logic [7:0] exp);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        address = 4'(a);
        cycle();
        chk($sformatf("read_w%0d", a), 32'(instr), 32'(exp));
    endtask

    initial begin
        m_known = '0;
        n_reset = 1'b0;
        address = '0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        m_phase = 0; m_hold = HOLD; m_ptr = 0; m_cnt = 0; m_sum = 0;

        // Reset held for 3 cycles in total, then the hold window
        cycle();
        cycle();
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_sum", 32'(checksum), 32'd0);
        chk("rst_cpu", 32'(cpu_n_reset), 32'd0);
        n_reset = 1'b1;
        cycle();
        chk("hold_1", 32'(cpu_n_reset), 32'd0);
        cycle();
        chk("hold_done", 32'(cpu_n_reset), 32'd1);
        cycle();

        // Full load of 0x00..0x0F
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i));
            #1 chk("full_ready", 32'(bus.wr_ready), 32'd1);
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("full_count", 32'(load_count), 32'd16);
        chk("full_sum", 32'(checksum), 32'h78);
        chk("full_ready_off", 32'(bus.wr_ready), 32'd0);
        cycle();
        chk("full_hold", 32'(cpu_n_reset), 32'd0);
        cycle();
        chk("full_run", 32'(cpu_n_reset), 32'd1);
        read_word(5, 8'h05);

        // Back-pressure: 8 bytes of 0xB3 with valid toggling, then load_end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, (i % 2) == 0, 8'hB3);
            cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        chk("bp_count", 32'(load_count), 32'd8);
        chk("bp_sum", 32'(checksum), 32'h98);
        for (int a = 0; a < 16; a++) read_word(a, (a < 8) ? 8'hB3 : 8'(a));

        // Restart mid-load: coincident 0xFF must be dropped
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
            cycle();
        end
        drive(1'b1, 1'b0, 1'b1, 8'hFF);
        #1 chk("restart_ready", 32'(bus.wr_ready), 32'd0);
        cycle();
        chk("restart_count", 32'(load_count), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'h21);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        chk("restart_count2", 32'(load_count), 32'd1);
        read_word(0, 8'h21);
        read_word(1, 8'h41);
        read_word(5, 8'hB3);

        // Reset in the middle of a load
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 8'h11); cycle();
        drive(1'b0, 1'b0, 1'b1, 8'h22); cycle();
        drive(1'b0, 1'b0, 1'b1, 8'h33); cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_reset = 1'b0;
        cycle();
        n_reset = 1'b1;
        chk("mid_rst_count", 32'(load_count), 32'd0);
        chk("mid_rst_sum", 32'(checksum), 32'd0);
        chk("mid_rst_loading", 32'(loading), 32'd0);
        read_word(0, 8'h11);
        read_word(1, 8'h22);
        read_word(2, 8'h33);

        // Read-during-write on word 0
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        address = 4'd0;
        drive(1'b0, 1'b0, 1'b1, 8'hE7);
        #1 chk("rdw_old", 32'(instr), 32'h11);
        cycle();
        chk("rdw_new", 32'(instr), 32'hE7);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        cycle();

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            n_reset = ($urandom_range(0, 60) != 0);
            address = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 25) == 0,
                  $urandom_range(0, 20) == 0,
                  $urandom_range(0, 1) == 1,
                  make_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- 16 x 8 program memory sitting directly upstream of the 4-bit CPU core.
- Read side: combinationally returns instr for the CPU's 4-bit address (PC).
- Write side: a valid/ready byte-stream loader fills the memory from address 0.
- Also owns the CPU's reset: cpu_n_reset is held low while a program is loaded and for a fixed number of cycles afterwards, so the CPU restarts at PC=0 on the new program.

Parameters:
- ADDR_W, 4, address width; matches the CPU PC width.
- DATA_W, 8, instruction width; upper nibble is opcode, lower nibble is immediate.
- DEPTH, 16, number of words; equals 2**ADDR_W.
- HOLD_CYCLES, 2, clock cycles cpu_n_reset stays low after a load or reset ends; must be 1 to 15.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- n_reset  in  1  synchronous, active-low reset, sampled on posedge clk.
- address  in  ADDR_W  read address from the CPU PC.
- instr  out  DATA_W  mem[address], combinational, zero latency.
- load_start  in  1  one-cycle pulse; begin or restart a load at word 0.
- load_end  in  1  one-cycle pulse; finish a load early.
- wr_valid  in  1  wr_data is valid.
- wr_data  in  DATA_W  instruction byte to store.
- wr_ready  out  1  loader accepts a byte this cycle.
- cpu_n_reset  out  1  registered, active-low synchronous reset to the CPU.
- loading  out  1  high while state is LOAD.
- load_count  out  ADDR_W+1  bytes accepted in the current or last load (0 to 16).
- checksum  out  8  mod-256 sum of bytes accepted in the current or last load.

Behaviour:
- Clock and reset: one clock (clk); reset n_reset is synchronous and active-low. All registers update on posedge clk only.
- Reset values:
  - state=HOLD, hold counter=HOLD_CYCLES, cpu_n_reset=0.
  - wr_ptr=0, load_count=0, checksum=0, loading=0, wr_ready=0.
- Memory array is not reset: contents persist across n_reset. Contents are undefined until the first load.
- Read path: instr = mem[address], purely combinational.
  - Same-address read during a write returns the old byte until the edge and the new byte after it.
- States:
  - HOLD: cpu_n_reset=0. Counter decrements each cycle. When the counter would reach 0, go to RUN; cpu_n_reset=1 from the next cycle. HOLD therefore lasts exactly HOLD_CYCLES cycles.
  - RUN: cpu_n_reset=1, wr_ready=0. load_start moves to LOAD.
  - LOAD: loading=1, cpu_n_reset=0.
    - wr_ready = 1 unless load_start is high this cycle.
    - Accept a byte when wr_valid && wr_ready: mem[wr_ptr] <= wr_data; wr_ptr++; load_count++; checksum <= checksum + wr_data (mod 256).
    - After accepting the byte at wr_ptr = DEPTH-1, go to HOLD with counter=HOLD_CYCLES. wr_ready=0 from the next cycle.
    - load_end: go to HOLD. A byte accepted in the same cycle is written first. Unwritten words keep their previous contents.
- load_start behaviour:
  - In HOLD or RUN: enter LOAD with wr_ptr=0, load_count=0, checksum=0, cpu_n_reset=0 from the next cycle.
  - In LOAD: restart the same way; any wr_valid that cycle is discarded because wr_ready=0.
- Priority when signals coincide: n_reset > load_start > (write, then load_end).
- wr_ready is never high outside LOAD.
- wr_ptr never wraps; the 16th accepted byte always ends the load.
- n_reset mid-load: load aborts and state goes to HOLD. Words already written stay written; load_count and checksum clear to 0.
- load_end in RUN or HOLD is ignored.
- load_count and checksum hold their values after a load completes, until the next load_start or n_reset.

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W=4, DATA_W=8.
  - Loader state enum {LD_HOLD, LD_RUN, LD_LOAD}.
  - Opcode field constants (instr[7:4]) for use by benches when building programs.
- One sub-module, prog_mem_array: 16 x 8 registers with one synchronous write port and one asynchronous read port.
- FSM, pointer, counter and checksum logic live in prog_mem_loader.

Test Plan:
- Reset: hold n_reset=0 for 3 cycles, then release. cpu_n_reset=0 for exactly 2 cycles after release, then 1. wr_ready=0 throughout; load_count=0 and checksum=0.
- Full load:
  - Stimulus: load_start, then 16 bytes 0x00..0x0F with wr_valid held high.
  - During the load: wr_ready=1 for 16 consecutive cycles.
  - After the last byte: load_count=16, checksum=0x78, cpu_n_reset=0 for 2 more cycles then 1.
  - Readback: address=5 gives instr=0x05.
- Back-pressure: toggle wr_valid 1,0,1,0 over 8 bytes 0xB3, then pulse load_end. load_count=8, checksum=0x98. Words 0..7 read 0xB3; words 8..15 keep prior values (0x08..0x0F).
- Restart: after 5 bytes, pulse load_start together with wr_valid and byte 0xFF. 0xFF is not written; load_count=0. The next byte 0x21 lands at word 0.
- Reset mid-load: after 3 bytes (0x11, 0x22, 0x33), assert n_reset for 1 cycle. State goes to HOLD; words 0..2 read 0x11/0x22/0x33; load_count=0; checksum=0.
- Read-during-write: hold address=0 while byte 0xE7 is written to word 0. instr shows the old value before the edge and 0xE7 after it.
